freq_counter: RTL and testbench
===============================

FREQ_COUNTER -- requirements
Module: freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 100000000: gate window length in cin cycles; legal range is 2 or more.
REQ-002 Parameter CNT_W, default 16: width of the edge-count result.
REQ-003 Port cin, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Port sig_in, input, 1: asynchronous slow signal whose rising edges are counted.
REQ-006 Port meas_en, input, 1: continuous-measurement enable; level-sensitive.
REQ-007 Port freq_count, output, CNT_W: rising edges counted in the last completed gate window.
REQ-008 Port freq_valid, output, 1: one-cycle pulse when freq_count is updated.
REQ-009 Port freq_ovf, output, 1: edge count saturated in the last completed window; updated together with freq_count.
REQ-010 Port busy, output, 1: high while a gate window is open.

Function
REQ-011 sig_in SHALL pass through a two-flop synchronizer, then a one-flop delayed copy.
- Edge pulse = synchronized value AND NOT delayed copy.
- A sig_in rise before edge N produces an edge pulse in cycle N+2.
REQ-012 The FSM SHALL have four states: IDLE, ARM, GATE and LATCH.
REQ-013 IDLE transitions:
- meas_en high: go to ARM next cycle.
- Otherwise: stay in IDLE.
REQ-014 ARM SHALL last one cycle.
- Clear the edge counter, the saturation flag and the gate counter.
- Go to GATE.
REQ-015 GATE SHALL last exactly GATE_CYCLES cycles, timed by the gate counter.
- Counts 0 to GATE_CYCLES-1.
- busy is high in every GATE cycle.
REQ-016 In each GATE cycle with an edge pulse, the edge counter SHALL increment by 1.
- If the counter is all-ones, it holds that value and the saturation flag sets instead.
REQ-017 Edge-pulse qualification by state:
- An edge pulse in the final GATE cycle SHALL be counted.
- Edge pulses in IDLE, ARM or LATCH SHALL be ignored.
REQ-018 LATCH SHALL last one cycle. On the following edge:
- freq_count loads the edge counter.
- freq_ovf loads the saturation flag.
- freq_valid is high for exactly that one following cycle.
REQ-019 LATCH exit:
- meas_en high: go to ARM (back-to-back windows, two dead cycles between windows).
- Otherwise: go to IDLE.
REQ-020 meas_en falling during GATE SHALL NOT abort the window; the window completes and reports per REQ-018.
REQ-021 freq_count and freq_ovf SHALL hold their last value between updates.
REQ-022 Counter widths:
- Gate counter width is clog2(GATE_CYCLES).
- No arithmetic wrap-around is permitted on either counter.

Reset
REQ-023 While rst_n is low at a cin edge, the following SHALL be set:
- state to IDLE;
- freq_count to 0, freq_valid to 0, freq_ovf to 0, busy to 0;
- both internal counters, the synchronizer flops and the delayed copy to 0.
REQ-024 Reset asserted mid-GATE SHALL discard the partial window; no freq_valid pulse follows.
REQ-025 After rst_n rises, the first window SHALL start only via IDLE, then ARM.

Structure
REQ-026 A shared package freq_counter_pkg SHALL hold:
- the FSM state type (IDLE, ARM, GATE, LATCH);
- the default GATE_CYCLES and CNT_W constants.
REQ-027 One sub-module, sync_edge_detect, SHALL contain the REQ-011 synchronizer and rising-edge detector.
- Its ports are cin, rst_n, async_in and rise_pulse.
REQ-028 All other logic SHALL reside in freq_counter.

Verification (bench uses GATE_CYCLES=100, CNT_W=16 unless stated)
REQ-029 Square-wave measurement:
- Stimulus: meas_en=1; sig_in square wave, period 10 cycles, phase such that no edge falls within 2 cycles of a window boundary.
- Response: freq_valid pulses with freq_count=10, freq_ovf=0, repeating every 102 cycles.
REQ-030 No edges:
- Stimulus: meas_en=1; sig_in held at 0.
- Response: freq_valid pulses with freq_count=0.
REQ-031 Saturation (CNT_W=4):
- Stimulus: 20 edges inside one window.
- Response: freq_count=15, freq_ovf=1.
- Next window with 3 edges: freq_count=3, freq_ovf=0.
REQ-032 Window-boundary edges:
- An edge pulse in the last GATE cycle is included in the count.
- An edge pulse in the LATCH cycle is excluded from both windows.
REQ-033 Reset mid-window:
- Stimulus: rst_n low for 1 cycle at GATE cycle 50.
- Response: all outputs 0 and state IDLE next cycle; no freq_valid for that window.
REQ-034 meas_en drop mid-window:
- Stimulus: meas_en=0 at GATE cycle 30.
- Response: exactly one freq_valid at window end, then busy stays 0 and no further pulses.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// Shared types and default sizing for the gated-window frequency counter.
package freq_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DEF_GATE_CYCLES = 100000000;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Purpose: two-flop synchronizer plus delayed copy, emits a one-cycle pulse per rising edge of async_in.
// Latency: a rise sampled at edge N is seen as a pulse by logic clocked at edge N+2.
// Backpressure: none; the pulse is combinational from the flops and never stalls.
module sync_edge_detect (
    input  logic cin,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge cin) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise_pulse = sync & ~sync_d;

endmodule

// File: rtl/freq_counter.sv
// Purpose: counts sig_in rising edges over a GATE_CYCLES window and reports the saturating total.
// Latency: result appears one cycle after the window closes; back-to-back windows repeat every GATE_CYCLES+2.
// Backpressure: none; freq_valid is a single-cycle pulse with no handshake.
module freq_counter
    import freq_counter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             freq_ovf,
    output logic             busy
);

    localparam int            GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     gate_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              sat;
    logic              rise;
    logic              gate_done;

    sync_edge_detect u_sync (
        .cin        (cin),
        .rst_n      (rst_n),
        .async_in   (sig_in),
        .rise_pulse (rise)
    );

    assign gate_done = (gate_cnt == GATE_LAST);
    assign busy      = (state == GATE);

    always_ff @(posedge cin) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (meas_en) state_nxt = ARM;
            ARM:     state_nxt = GATE;
            GATE:    if (gate_done) state_nxt = LATCH;
            LATCH:   state_nxt = meas_en ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The gate counter parks at its last value instead of wrapping; ARM reloads it.
    always_ff @(posedge cin) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
        end else begin
            freq_valid <= (state == LATCH);
            case (state)
                ARM: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat      <= 1'b0;
                end
                GATE: begin
                    if (!gate_done) gate_cnt <= gate_cnt + 1'b1;
                    if (rise) begin
                        if (&edge_cnt) sat <= 1'b1;
                        else           edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    freq_count <= edge_cnt;
                    freq_ovf   <= sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_counter.sv
// Randomized scoreboard bench: a window-level reference model predicts each result, a monitor pops on freq_valid.
module tb_freq_counter;

    localparam int G = 100;

    logic        cin = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic        meas_en = 1'b0;
    logic [15:0] fc16;
    logic        fv16, fo16, b16;
    logic [3:0]  fc4;
    logic        fv4, fo4, b4;

    int errors = 0;
    int checks = 0;

    // Reference model state: phase -1 = idle, 0 = arm, 1..G = gate cycle, G+1 = latch.
    int phase = -1;
    int cnt = 0;
    bit hist[$];
    int expq[$];

    freq_counter #(.GATE_CYCLES(G), .CNT_W(16)) dut16 (
        .cin(cin), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en),
        .freq_count(fc16), .freq_valid(fv16), .freq_ovf(fo16), .busy(b16)
    );

    freq_counter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
        .cin(cin), .rst_n(rst_n), .sig_in(sig_in), .meas_en(meas_en),
        .freq_count(fc4), .freq_valid(fv4), .freq_ovf(fo4), .busy(b4)
    );

    always #5 cin = ~cin;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a rise on sig_in sampled at edge k is a countable pulse at edge k+2.
    always @(posedge cin) begin : model
        bit pulse;
        if (!rst_n) begin
            phase = -1;
            cnt   = 0;
            hist  = '{1'b0, 1'b0, 1'b0};
        end else begin
            pulse = hist[hist.size()-2] && !hist[hist.size()-3];
            if (phase == 0) cnt = 0;
            else if (phase >= 1 && phase <= G && pulse) cnt = cnt + 1;
            if (phase == G + 1) expq.push_back(cnt);
            if (phase == -1 || phase == G + 1) phase = meas_en ? 0 : -1;
            else phase = phase + 1;
            hist.push_back(sig_in);
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    always @(negedge cin) begin : monitor
        int e;
        chk("busy16", int'(b16), int'(phase >= 1 && phase <= G));
        chk("busy4",  int'(b4),  int'(phase >= 1 && phase <= G));
        if (fv16 || fv4) begin
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("valid16", int'(fv16), 1);
                chk("valid4",  int'(fv4), 1);
                chk("count16", int'(fc16), e);
                chk("ovf16",   int'(fo16), 0);
                chk("count4",  int'(fc4), (e > 15) ? 15 : e);
                chk("ovf4",    int'(fo4), int'(e > 15));
            end
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(negedge cin);
            n++;
        end while (phase != p && n < 1000);
        chk("wait_phase_timeout", int'(phase == p), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_count16"}, int'(fc16), 0);
        chk({tag, "_count4"},  int'(fc4), 0);
        chk({tag, "_valid"},   int'(fv16), 0);
        chk({tag, "_ovf"},     int'(fo4), 0);
        chk({tag, "_busy"},    int'(b16), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge cin);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Square wave, period 10 cycles.
        meas_en = 1'b1;
        for (int i = 0; i < 330; i++) begin
            @(negedge cin);
            if (i % 5 == 0) sig_in = ~sig_in;
        end

        // No edges.
        sig_in = 1'b0;
        repeat (220) @(negedge cin);

        // Dense random toggling saturates the 4-bit instance.
        repeat (320) begin
            @(negedge cin);
            sig_in = 1'($urandom_range(0, 1));
        end

        // Sparse toggling: a few edges per window, overflow must clear.
        repeat (320) begin
            @(negedge cin);
            if ($urandom_range(0, 30) == 0) sig_in = ~sig_in;
        end

        // Edge pulse landing in the last gate cycle, then one landing in latch.
        sig_in = 1'b0;
        wait_phase(G - 2);
        sig_in = 1'b1;
        wait_phase(10);
        sig_in = 1'b0;
        wait_phase(G - 1);
        sig_in = 1'b1;
        wait_phase(10);
        sig_in = 1'b0;

        // meas_en drops mid-window: window completes, then the block goes idle.
        wait_phase(30);
        meas_en = 1'b0;
        repeat (300) @(negedge cin);
        chk("idle_after_drop", int'(b16), 0);

        // Reset mid-window discards the partial count.
        meas_en = 1'b1;
        for (int i = 0; i < 2 * G + 60; i++) begin
            @(negedge cin);
            if (i % 4 == 0) sig_in = ~sig_in;
        end
        wait_phase(50);
        rst_n = 1'b0;
        @(negedge cin);
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge cin);
            if (i % 6 == 0) sig_in = ~sig_in;
        end

        meas_en = 1'b0;
        repeat (250) @(negedge cin);
        chk("pending_results", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
